// File: rtl/inst_decode_stage.sv
// RV32I decode stage: decodes each fetched word at push time into a two-entry FIFO
// that feeds the execute stage. Optional macro IDU_RV32E_EN limits register fields to x0..x15.
module inst_decode_stage #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IFU_done,
    input  logic [31:0] instruction,
    input  logic [31:0] pc,
    input  logic        exu_ready,
    output logic        dec_valid,
    output logic [31:0] dec_pc,
    output logic [6:0]  dec_opcode,
    output logic [4:0]  dec_rd,
    output logic [4:0]  dec_rs1,
    output logic [4:0]  dec_rs2,
    output logic [2:0]  dec_funct3,
    output logic [6:0]  dec_funct7,
    output logic [31:0] dec_imm,
    output logic [2:0]  dec_imm_type,
    output logic        dec_illegal,
    output logic        dec_ebreak,
    output logic        fetch_stall,
    output logic        overflow
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic [2:0]  imm_type;
        logic        illegal;
        logic        ebreak;
    } entry_t;

    entry_t     mem [2];
    entry_t     dec_in;
    entry_t     head;
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic [1:0] count_next;
    logic       push;
    logic       pop;
    logic       is_op;

    // Handshake: an entry transfers to execute on any rising edge where dec_valid and
    // exu_ready are both high; the head stays unchanged otherwise.
    assign pop  = (count != 2'd0) & exu_ready;
    assign push = IFU_done & ((count < FULL) | pop);

    always_comb begin
        dec_in          = '0;
        is_op           = 1'b0;
        dec_in.pc       = pc;
        dec_in.opcode   = instruction[6:0];
        dec_in.rd       = instruction[11:7];
        dec_in.funct3   = instruction[14:12];
        dec_in.rs1      = instruction[19:15];
        dec_in.rs2      = instruction[24:20];
        dec_in.funct7   = instruction[31:25];
        dec_in.ebreak   = (instruction == 32'h0010_0073);
        case (instruction[6:0])
            7'b0110111, 7'b0010111: begin
                dec_in.imm_type = IMM_U;
                dec_in.imm      = {instruction[31:12], 12'b0};
            end
            7'b1101111: begin
                dec_in.imm_type = IMM_J;
                dec_in.imm      = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                                   instruction[20], instruction[30:21], 1'b0};
            end
            7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011: begin
                dec_in.imm_type = IMM_I;
                dec_in.imm      = {{20{instruction[31]}}, instruction[31:20]};
            end
            7'b0100011: begin
                dec_in.imm_type = IMM_S;
                dec_in.imm      = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            end
            7'b1100011: begin
                dec_in.imm_type = IMM_B;
                dec_in.imm      = {{19{instruction[31]}}, instruction[31], instruction[7],
                                   instruction[30:25], instruction[11:8], 1'b0};
            end
            7'b0110011: begin
                is_op = 1'b1;
            end
            default: begin
                dec_in.illegal = 1'b1;
            end
        endcase
`ifdef IDU_RV32E_EN
        // Only 16 registers exist: any field the format actually reads or writes must be < 16.
        if ((dec_in.rd[4] & (is_op | dec_in.imm_type inside {IMM_U, IMM_J, IMM_I})) |
            (dec_in.rs1[4] & (is_op | dec_in.imm_type inside {IMM_I, IMM_S, IMM_B})) |
            (dec_in.rs2[4] & (is_op | dec_in.imm_type inside {IMM_S, IMM_B}))) begin
            dec_in.illegal = 1'b1;
        end
`endif
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    // At count 2 with push and pop, wr_ptr equals rd_ptr: the slot being vacated is refilled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            fetch_stall <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= dec_in;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count       <= count_next;
            fetch_stall <= (count_next == FULL);
            overflow    <= overflow | (IFU_done & ~push);
        end
    end

    assign head         = mem[rd_ptr];
    assign dec_valid    = (count != 2'd0);
    assign dec_pc       = head.pc;
    assign dec_opcode   = head.opcode;
    assign dec_rd       = head.rd;
    assign dec_rs1      = head.rs1;
    assign dec_rs2      = head.rs2;
    assign dec_funct3   = head.funct3;
    assign dec_funct7   = head.funct7;
    assign dec_imm      = head.imm;
    assign dec_imm_type = head.imm_type;
    assign dec_illegal  = head.illegal;
    assign dec_ebreak   = head.ebreak;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Bench for inst_decode_stage: directed cases plus random traffic, scoreboarded against
// an arithmetic reference decoder and a queue model of the two-entry buffer.
module tb_inst_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        IFU_done;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        exu_ready;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [6:0]  dec_opcode;
    logic [4:0]  dec_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [2:0]  dec_funct3;
    logic [6:0]  dec_funct7;
    logic [31:0] dec_imm;
    logic [2:0]  dec_imm_type;
    logic        dec_illegal;
    logic        dec_ebreak;
    logic        fetch_stall;
    logic        overflow;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic [2:0]  imm_type;
        logic        illegal;
        logic        ebreak;
    } exp_t;

    localparam int EW = $bits(exp_t);

    logic [EW-1:0] exp_q[$];
    exp_t          act;
    int            tests = 0;
    int            fails = 0;
    int            cur_count = 0;
    int            nxt_count = 0;
    bit            cur_ovf = 1'b0;
    bit            nxt_ovf = 1'b0;
    bit            mon_en = 1'b0;
    logic [6:0]    ops [11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h03, 7'h13,
                                7'h73, 7'h23, 7'h63, 7'h33, 7'h7f};

    inst_decode_stage #(.DEPTH(2)) dut (
        .clk(clk), .rst(rst), .IFU_done(IFU_done), .instruction(instruction), .pc(pc),
        .exu_ready(exu_ready), .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_opcode(dec_opcode),
        .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_funct3(dec_funct3),
        .dec_funct7(dec_funct7), .dec_imm(dec_imm), .dec_imm_type(dec_imm_type),
        .dec_illegal(dec_illegal), .dec_ebreak(dec_ebreak), .fetch_stall(fetch_stall),
        .overflow(overflow)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic void check(string name, logic [127:0] got, logic [127:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endfunction

    // Reference decoder: immediates built as signed sums of their bit-field weights.
    function automatic exp_t ref_decode(logic [31:0] i, logic [31:0] a);
        exp_t e;
        int   imm;
        int   fmt;
        bit   s;
        s = i[31];
        e = '0;
        e.pc = a;  e.opcode = i[6:0];  e.rd = i[11:7];  e.funct3 = i[14:12];
        e.rs1 = i[19:15];  e.rs2 = i[24:20];  e.funct7 = i[31:25];
        e.ebreak = (i == 32'h0010_0073);
        imm = 0;
        fmt = 0;
        case (i[6:0])
            7'h37, 7'h17: begin fmt = 4; imm = int'(i & 32'hffff_f000); end
            7'h6f: begin
                fmt = 5;
                imm = (s ? -(1 << 20) : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048
                      + int'(i[30:21]) * 2;
            end
            7'h67, 7'h03, 7'h13, 7'h73: begin fmt = 1; imm = (s ? -2048 : 0) + int'(i[30:20]); end
            7'h23: begin
                fmt = 2;
                imm = (s ? -2048 : 0) + int'(i[30:25]) * 32 + int'(i[11:7]);
            end
            7'h63: begin
                fmt = 3;
                imm = (s ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32
                      + int'(i[11:8]) * 2;
            end
            7'h33: fmt = 6;
            default: e.illegal = 1'b1;
        endcase
        e.imm_type = (fmt == 6) ? 3'd0 : 3'(fmt);
        e.imm = 32'(imm);
`ifdef IDU_RV32E_EN
        if ((e.rd >= 16 && fmt inside {1, 4, 5, 6}) ||
            (e.rs1 >= 16 && fmt inside {1, 2, 3, 6}) ||
            (e.rs2 >= 16 && fmt inside {2, 3, 6}))
            e.illegal = 1'b1;
`endif
        return e;
    endfunction

    // driver: one cycle of stimulus, queue-model prediction of the coming edge
    task automatic cycle(bit v, logic [31:0] ins, logic [31:0] a, bit rdy);
        bit do_pop;
        bit do_push;
        IFU_done = v;  instruction = ins;  pc = a;  exu_ready = rdy;
        do_pop  = (cur_count != 0) && rdy;
        do_push = v && (cur_count < 2 || do_pop);
        if (do_push) exp_q.push_back(ref_decode(ins, a));
        nxt_count = cur_count + int'(do_push) - int'(do_pop);
        nxt_ovf   = cur_ovf | (v & !do_push);
        @(posedge clk);
        #1;
        cur_count = nxt_count;
        cur_ovf   = nxt_ovf;
    endtask

    task automatic rand_cycle();
        logic [31:0] r;
        r = $urandom();
        r[6:0] = ops[$urandom_range(0, 10)];
        if ($urandom_range(0, 19) == 0) r = 32'h0010_0073;
        cycle($urandom_range(0, 9) < 6, r, $urandom() & 32'hffff_fffc, $urandom_range(0, 1) == 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 8 && cur_count != 0; k++) cycle(1'b0, 32'h0, 32'h0, 1'b1);
        check("drain_valid", dec_valid, 1'b0);
    endtask

    // scoreboard monitor: samples on the falling edge
    always @(negedge clk) begin
        if (mon_en && rst) begin
            check("valid", dec_valid, cur_count != 0);
            check("stall", fetch_stall, cur_count == 2);
            check("overflow", overflow, cur_ovf);
            if (dec_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL head: DUT valid but no expected entry queued");
                end else begin
                    act = '{dec_pc, dec_opcode, dec_rd, dec_rs1, dec_rs2, dec_funct3, dec_funct7,
                            dec_imm, dec_imm_type, dec_illegal, dec_ebreak};
                    check("head", act, exp_q[0]);
                    if (exu_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;  IFU_done = 1'b0;  instruction = '0;  pc = '0;  exu_ready = 1'b0;
        #12;
        check("rst_valid", dec_valid, 1'b0);
        check("rst_stall", fetch_stall, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_imm", dec_imm, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        mon_en = 1'b1;

        // addi, jal, beq
        cycle(1'b1, 32'hfff0_0093, 32'h8000_0000, 1'b1);
        check("addi_valid", dec_valid, 1'b1);
        check("addi_rd", dec_rd, 5'd1);
        check("addi_rs1", dec_rs1, 5'd0);
        check("addi_imm", dec_imm, 32'hffff_ffff);
        check("addi_type", dec_imm_type, 3'd1);
        check("addi_pc", dec_pc, 32'h8000_0000);
        cycle(1'b1, 32'h0080_00ef, 32'h8000_0004, 1'b1);
        check("jal_imm", dec_imm, 32'h0000_0008);
        check("jal_type", dec_imm_type, 3'd5);
        cycle(1'b1, 32'hfe00_0ee3, 32'h8000_0008, 1'b1);
        check("beq_imm", dec_imm, 32'hffff_fffc);
        check("beq_type", dec_imm_type, 3'd3);
        drain();

        // fill, overflow, drain in order
        cycle(1'b1, 32'h0000_0013, 32'h100, 1'b0);
        cycle(1'b1, 32'h0010_0113, 32'h104, 1'b0);
        check("full_stall", fetch_stall, 1'b1);
        cycle(1'b1, 32'h0020_0193, 32'h108, 1'b0);
        check("ovf_set", overflow, 1'b1);
        check("ovf_head_pc", dec_pc, 32'h100);
        cycle(1'b0, 32'h0, 32'h0, 1'b1);
        check("pop1_pc", dec_pc, 32'h104);
        cycle(1'b0, 32'h0, 32'h0, 1'b1);
        check("pop2_valid", dec_valid, 1'b0);

        // full with simultaneous push and pop
        cycle(1'b1, 32'h0030_0213, 32'h200, 1'b0);
        cycle(1'b1, 32'h0040_0293, 32'h204, 1'b0);
        cycle(1'b1, 32'h0050_0313, 32'h208, 1'b1);
        check("pp_stall", fetch_stall, 1'b1);
        check("pp_head_pc", dec_pc, 32'h204);
        drain();

        // ebreak, illegal opcode, RV32E register range
        cycle(1'b1, 32'h0010_0073, 32'h300, 1'b0);
        check("ebreak", dec_ebreak, 1'b1);
        cycle(1'b1, 32'h0000_007f, 32'h304, 1'b1);
        check("illegal", dec_illegal, 1'b1);
        check("illegal_imm", dec_imm, 32'h0);
        cycle(1'b1, 32'h0010_0813, 32'h308, 1'b1);
        check("x16_rd", dec_rd, 5'd16);
`ifdef IDU_RV32E_EN
        check("x16_illegal", dec_illegal, 1'b1);
`else
        check("x16_illegal", dec_illegal, 1'b0);
`endif

        // reset mid-stream
        cycle(1'b1, 32'h0000_0013, 32'h400, 1'b0);
        cycle(1'b1, 32'h0000_0013, 32'h404, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", dec_valid, 1'b0);
        check("mid_rst_stall", fetch_stall, 1'b0);
        check("mid_rst_ovf", overflow, 1'b0);
        check("mid_rst_pc", dec_pc, 32'h0);
        exp_q.delete();
        cur_count = 0;
        cur_ovf = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle(1'b1, 32'hfff0_0093, 32'h500, 1'b0);
        check("post_rst_valid", dec_valid, 1'b1);
        check("post_rst_pc", dec_pc, 32'h500);

        for (int n = 0; n < 600; n++) rand_cycle();
        drain();
        check("queue_empty", exp_q.size(), 0);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inst_decode_stage.md
# inst_decode_stage

Decode stage directly downstream of the instruction fetch unit. Captures each fetched word on the fetch-done pulse and decodes it as an RV32I base instruction. Buffers up to two decoded instructions in a small FIFO and presents them to the execute stage over a valid/ready handshake. Asserts a stall back to fetch when the buffer is full.

## Interface
Parameters:
- DEPTH, 2, FIFO entries; only 2 is supported.

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-low (asserted at 0)
- IFU_done  in  1  fetch-complete pulse; instruction/pc valid this cycle
- instruction  in  32  fetched word
- pc  in  32  address of the fetched word
- exu_ready  in  1  execute stage accepts the head entry this cycle
- dec_valid  out  1  head entry present
- dec_pc  out  32  head pc
- dec_opcode  out  7  inst[6:0]
- dec_rd / dec_rs1 / dec_rs2  out  5 each  inst[11:7] / [19:15] / [24:20]
- dec_funct3  out  3  inst[14:12]
- dec_funct7  out  7  inst[31:25]
- dec_imm  out  32  sign-extended immediate
- dec_imm_type  out  3  0=none, 1=I, 2=S, 3=B, 4=U, 5=J
- dec_illegal  out  1  head is illegal
- dec_ebreak  out  1  head equals 0x00100073
- fetch_stall  out  1  buffer full; fetch must hold off
- overflow  out  1  sticky: a push was dropped

## Operation
- Decode is done at push time. The entry stores all dec_* fields, so the outputs are registered.
- Opcode classes:
  - LUI 0110111 and AUIPC 0010111 give U: {inst[31:12],12'b0}.
  - JAL 1101111 gives J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - JALR 1100111, LOAD 0000011, OP-IMM 0010011 and SYSTEM 1110011 give I: inst[31:20].
  - STORE 0100011 gives S: {inst[31:25], inst[11:7]}.
  - BRANCH 1100011 gives B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - OP 0110011 gives none, imm=0.
  - All immediates are sign-extended from the top bit of their encoding to 32 bits.
- Any other opcode sets dec_illegal=1, imm_type=0, imm=0. The other fields are still passed through raw.
- push = IFU_done & (count<2 | pop).
- pop = dec_valid & exu_ready.
- FIFO behaviour:
  - Push and pop in the same cycle is legal at any count.
  - At count 2 with a simultaneous pop, the push is accepted.
  - The head always leaves before the new entry.
- IFU_done with count==2 and no pop: the word is dropped, overflow is set to 1 and held until reset.
- dec_valid = (count != 0). The head fields hold steady while dec_valid=1 and exu_ready=0.
- fetch_stall = (count == 2). It is registered, not a function of exu_ready.
- Pointers: 1-bit read/write indices wrap 1→0. count is 2 bits, range 0..2.

## Timing
- Reset (rst=0, any time, asynchronous): count=0, pointers=0, dec_valid=0, fetch_stall=0, overflow=0.
  - All dec_* data outputs reset to 0.
  - Any in-flight entries are discarded.
- Latency: IFU_done at edge N (sampled) gives dec_valid=1 with fields after edge N, i.e. one cycle.
- Throughput: one push and one pop per cycle.
- Pop at edge N with a second entry present: the second entry is at the head immediately after N.
- When rst is released, the first IFU_done is honoured on the next rising edge.

## Configuration
- Macro IDU_RV32E_EN.
- Defined: the register file is 16 entries. Any register field used by the decoded format with bit 4 set makes the entry illegal (dec_illegal=1). Field usage:
  - rd: U, J, I, OP.
  - rs1: I, S, B, OP.
  - rs2: S, B, OP.
- Not defined: 32 registers; no register-range check.

## Test plan
- Push 0xfff00093 (addi x1,x0,-1), pc=0x80000000, exu_ready=1 → next cycle dec_valid=1, rd=1, rs1=0, imm=0xffffffff, imm_type=1, pc=0x80000000.
- Push 0x008000ef (jal x1,8) → imm=0x00000008, imm_type=5; push 0xfe000ee3 (beq x0,x0,-4) → imm=0xfffffffc, imm_type=3.
- exu_ready=0, three IFU_done pulses → after the 2nd, fetch_stall=1; the 3rd is dropped and overflow=1. Then exu_ready=1 → the first two pop in order, count returns to 0.
- count=2, IFU_done and exu_ready high together → head pops, new word is pushed, count stays 2, order preserved.
- Push 0x00100073 → dec_ebreak=1. Push 0x0000007f → dec_illegal=1, imm=0. Assert rst=0 mid-stream → dec_valid=0 immediately.
- With IDU_RV32E_EN, push 0x00100813 (addi x16,x0,1) → dec_illegal=1. Without the macro → legal, rd=16.
